sum_event_detect: RTL

//   Consumes the 3-sample moving sum (signed 8-bit) and detects "events" with a

---
 rtl/sum_event_detect_if.sv | 26 ++
 rtl/sum_event_detect.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/sum_event_detect_if.sv
// Sample/event bus between the moving-sum stage, sum_event_detect and its consumer.
// CNT_W must match the CNT_W of the attached sum_event_detect.
interface sum_event_detect_if #(
  parameter int unsigned CNT_W = 8
);
  logic                    en;
  logic signed [7:0]       sum_in;
  logic signed [7:0]       thr_hi;
  logic signed [7:0]       thr_lo;
  logic                    active;
  logic                    evt_start;
  logic                    evt_end;
  logic        [CNT_W-1:0] len_out;
  logic signed [7:0]       peak_out;
  logic                    timeout;

  modport master (
    output en, sum_in, thr_hi, thr_lo,
    input  active, evt_start, evt_end, len_out, peak_out, timeout
  );

  modport slave (
    input  en, sum_in, thr_hi, thr_lo,
    output active, evt_start, evt_end, len_out, peak_out, timeout
  );
endinterface

// File: rtl/sum_event_detect.sv
// Hysteresis event detector on the signed 3-sample moving sum.
// Optional: define EVT_TIMEOUT_EN to end an event when its length counter would overflow.
module sum_event_detect #(
  parameter int unsigned MIN_LEN = 2,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  sum_event_detect_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARM    = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [7:0]       peak_q, peak_d;
  logic                    active_q, active_d;
  logic                    evt_start_q, evt_start_d;
  logic                    evt_end_q, evt_end_d;
  logic                    timeout_q, timeout_d;
  logic [CNT_W-1:0]        len_out_q, len_out_d;
  logic signed [7:0]       peak_out_q, peak_out_d;

  logic                    above;
  logic                    below;
  logic signed [7:0]       peak_max;
  logic [CNT_W-1:0]        cnt_inc;

  assign above    = $signed(bus.sum_in) > $signed(bus.thr_hi);
  assign below    = $signed(bus.sum_in) < $signed(bus.thr_lo);
  assign peak_max = ($signed(bus.sum_in) > peak_q) ? bus.sum_in : peak_q;
  assign cnt_inc  = cnt_q + CNT_W'(1);

  // Next-state and registered-output decode; everything holds unless en=1
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    peak_d      = peak_q;
    evt_start_d = 1'b0;
    evt_end_d   = 1'b0;
    timeout_d   = 1'b0;
    len_out_d   = len_out_q;
    peak_out_d  = peak_out_q;

    if (bus.en) begin
      case (state_q)
        S_IDLE: begin
          if (above) begin
            cnt_d  = CNT_W'(1);
            peak_d = bus.sum_in;
            if (MIN_LEN == 1) begin
              state_d     = S_ACTIVE;
              evt_start_d = 1'b1;
            end else begin
              state_d = S_ARM;
            end
          end
        end
        S_ARM: begin
          if (above) begin
            cnt_d  = cnt_inc;
            peak_d = peak_max;
            if (cnt_inc == CNT_W'(MIN_LEN)) begin
              state_d     = S_ACTIVE;
              evt_start_d = 1'b1;
            end
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
            peak_d  = '0;
          end
        end
        S_ACTIVE: begin
          if (below) begin
            // Ending sample is excluded from both length and peak
            state_d    = S_IDLE;
            evt_end_d  = 1'b1;
            len_out_d  = cnt_q;
            peak_out_d = peak_q;
            cnt_d      = '0;
            peak_d     = '0;
          end else if (cnt_q == CNT_MAX) begin
`ifdef EVT_TIMEOUT_EN
            state_d    = S_IDLE;
            evt_end_d  = 1'b1;
            timeout_d  = 1'b1;
            len_out_d  = CNT_MAX;
            peak_out_d = peak_max;
            cnt_d      = '0;
            peak_d     = '0;
`else
            peak_d = peak_max;
`endif
          end else begin
            cnt_d  = cnt_inc;
            peak_d = peak_max;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          peak_d  = '0;
        end
      endcase
    end

    active_d = (state_d == S_ACTIVE);
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      peak_q      <= '0;
      active_q    <= 1'b0;
      evt_start_q <= 1'b0;
      evt_end_q   <= 1'b0;
      timeout_q   <= 1'b0;
      len_out_q   <= '0;
      peak_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      peak_q      <= peak_d;
      active_q    <= active_d;
      evt_start_q <= evt_start_d;
      evt_end_q   <= evt_end_d;
      timeout_q   <= timeout_d;
      len_out_q   <= len_out_d;
      peak_out_q  <= peak_out_d;
    end
  end

  assign bus.active    = active_q;
  assign bus.evt_start = evt_start_q;
  assign bus.evt_end   = evt_end_q;
  assign bus.timeout   = timeout_q;
  assign bus.len_out   = len_out_q;
  assign bus.peak_out  = peak_out_q;

endmodule
